// File: rtl/sub_bytes_serial_if.sv
// rtl/sub_bytes_serial_if.sv - state-in / state-out handshake bundle for sub_bytes_serial
interface sub_bytes_serial_if #(
  parameter int NBYTES = 16
);
  logic                  dec;
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;
  logic                  busy;

  modport master (
    output dec, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  dec, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - byte-serial SubBytes/InvSubBytes over a full AES state
// Optional macro SUB_BYTES_BACK2BACK_EN: accept the next state in DONE during handoff.
module sub_bytes_serial #(
  parameter int NBYTES = 16,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst,
  sub_bytes_serial_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] e;
    r  = 8'h01;
    sq = a;
    e  = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] b);
    return b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_aff(input logic [7:0] s);
    return rol(s, 1) ^ rol(s, 3) ^ rol(s, 6) ^ 8'h05;
  endfunction

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [8*NBYTES-1:0] r_data;
  logic                r_dec;
  logic [8*NBYTES-1:0] r_out;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_in_ready;
  logic                w_accept;
  logic [7:0]          w_byte;
  logic [7:0]          w_pre;
  logic [7:0]          w_inv;
  logic [7:0]          w_sub;

  // Forward and inverse share one field inverter; only the affine step moves.
  assign w_byte = r_data[8*r_cnt +: 8];
  assign w_pre  = r_dec ? inv_aff(w_byte) : w_byte;
  assign w_inv  = gf_inv(w_pre);
  assign w_sub  = r_dec ? w_inv : aff(w_inv);

`ifdef SUB_BYTES_BACK2BACK_EN
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
`else
  assign w_in_ready = (r_state == S_IDLE);
`endif
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_dec       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= bus.in_data;
            r_dec   <= bus.dec;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_out[8*r_cnt +: 8] <= w_sub;
          if (r_cnt == LAST) begin
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_data  <= bus.in_data;
              r_dec   <= bus.dec;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = r_busy;
endmodule

// File: doc/sub_bytes_serial.md
Name: sub_bytes_serial

Overview:
Byte-serial SubBytes/InvSubBytes engine for a full AES state. It accepts a 128-bit state over a valid/ready handshake and walks its bytes one per clock through the existing sbox or inv_sbox (ports U/S). It reassembles the substituted bytes into a 128-bit result presented on a second valid/ready handshake. It is the state-level consumer/producer counterpart of the byte-wide S-box datapath and sits between the round-state register and the cipher round logic.

Parameters:
NBYTES, 16, bytes per state; state width = 8*NBYTES.
CNT_W, 4, counter width; must satisfy 2**CNT_W >= NBYTES.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
dec  input  1  mode: 0 = forward S-box, 1 = inverse S-box; sampled only at input accept.
in_valid  input  1  input state valid.
in_ready  output  1  block can accept a state.
in_data  input  8*NBYTES  input state; byte i = bits [8i+7:8i].
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_data  output  8*NBYTES  substituted state, same byte ordering.
busy  output  1  high in RUN.

Behaviour:
- The state is clk/rst only; there is one clock. rst is asynchronous, active-high.
- While rst is high or after reset: FSM=IDLE, counter=0, captured state=0, captured mode=0, out_data=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge, capture in_data and dec, clear the counter, and go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle, byte[counter] of the captured state feeds sbox (mode 0) or inv_sbox (mode 1) combinationally. At the edge, the result is written to out_data byte[counter] and the counter increments. When the counter equals NBYTES-1 at the edge, go to DONE and set out_valid=1.
  - DONE: out_valid=1, and out_data is held stable. On out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly NBYTES clock edges after the accept edge (16 for the default).
- Throughput: one state per NBYTES+2 cycles without the optional feature, with out_ready held high.
- Byte order: byte 0 (LSB) is processed first and byte NBYTES-1 last.
- Bytes of out_data not yet written in RUN keep their previous values. Only a fully assembled state is valid while out_valid=1.
- in_data and dec changes after the accept edge have no effect. in_valid asserted outside IDLE is ignored and not queued.
- out_ready while out_valid=0 is ignored.
- rst asserted mid-RUN or in DONE aborts immediately to the reset values. No partial result is emitted.
- The counter never exceeds NBYTES-1 and has no wrap-around inside a run.

Optional Feature:
SUB_BYTES_BACK2BACK_EN
- Defined: in_ready = IDLE || (DONE && out_ready). An accept in DONE simultaneous with result handoff clears out_valid, captures the new state and mode, clears the counter, and enters RUN directly. This gives one state per NBYTES+1 cycles.
- Undefined: in_ready is high only in IDLE, so one idle cycle separates consecutive states.

Test Plan:
- Reset, then forward mode: in_data=0x00112233445566778899aabbccddeeff, dec=0, out_ready=1 -> after 16 edges out_data=0x638293c31bfc33f5c4eeacea4bc12816 and out_valid=1 for one cycle; busy high for 16 cycles.
- Inverse round trip: feed the previous result with dec=1 -> out_data=0x00112233445566778899aabbccddeeff.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid is ignored; out_ready=1 -> handoff, in_ready=1 next cycle.
- Mode capture: in_data all 0x53, dec=0 at accept, toggle dec during RUN -> all bytes 0xED.
- Reset mid-run: assert rst at cycle 8 of RUN -> out_valid=0, out_data=0, in_ready=1 after release; a new all-0x00 state yields all-0x63.
- With SUB_BYTES_BACK2BACK_EN: two states with in_valid and out_ready held high -> second out_valid rises 17 edges after the first. Without the macro -> 18 edges.
